// File: rtl/ib_lut_mem_ctrl_pkg.sv
// Shared constants, FSM state type and sizing for the IB LUT memory controller.
// Resize the LUT here; the controller and arbiter pick the values up by import.
package ib_lut_ctrl_pkg;

  localparam int QUAN_SIZE       = 3;
  localparam int PAGE_NUM        = 16;
  // Only an interleave of 2 is supported by the page packer.
  localparam int BANK_INTERLEAVE = 2;
  localparam int ADDR_BITWIDTH   = 4;
  localparam int PAGE_SIZE       = QUAN_SIZE * BANK_INTERLEAVE;
  localparam int REQ_NUM         = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    READY = 2'd2
  } state_t;

endpackage

// File: rtl/ib_lut_mem_ctrl_arb.sv
// Two-input round-robin arbiter: one grant per cycle, ties go to the requester
// that was not served last. rr_last starts at 1 so r0 wins the first tie.
module rr_arbiter_2
  import ib_lut_ctrl_pkg::*;
(
  input  logic               sys_clk,
  input  logic               rstn,
  input  logic               en,
  input  logic [REQ_NUM-1:0] req,
  output logic [REQ_NUM-1:0] gnt
);

  logic rr_last_q;

  always_comb begin
    gnt = '0;
    if (en) begin
      if (req[0] && req[1]) begin
        gnt = rr_last_q ? {1'b0, 1'b1} : {1'b1, 1'b0};
      end else begin
        gnt = req;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      rr_last_q <= 1'b1;
    end else if (|gnt) begin
      rr_last_q <= gnt[1];
    end
  end

endmodule

// File: rtl/ib_lut_mem_ctrl.sv
// IB LUT memory controller: packs the serial config stream into pages, then
// serves round-robin single-word reads with a fixed two-cycle return latency.
module ib_lut_mem_ctrl
  import ib_lut_ctrl_pkg::*;
(
  input  logic                     sys_clk,
  input  logic                     rstn,
  input  logic                     load_start_i,
  input  logic                     load_valid_i,
  input  logic [QUAN_SIZE-1:0]     load_word_i,
  output logic                     load_done_o,
  output logic                     busy_o,
  input  logic                     r0_req_i,
  input  logic                     r1_req_i,
  input  logic [ADDR_BITWIDTH:0]   r0_addr_i,
  input  logic [ADDR_BITWIDTH:0]   r1_addr_i,
  output logic                     r0_gnt_o,
  output logic                     r1_gnt_o,
  output logic                     r0_rd_valid_o,
  output logic                     r1_rd_valid_o,
  output logic [QUAN_SIZE-1:0]     rd_word_o,
  output logic [ADDR_BITWIDTH-1:0] mem_addr_o,
  output logic                     mem_we_o,
  output logic [PAGE_SIZE-1:0]     mem_wdata_o,
  output logic                     mem_strobe_o,
  input  logic [QUAN_SIZE-1:0]     mem_word_i
);

  localparam logic [ADDR_BITWIDTH:0] PAGE_END = (ADDR_BITWIDTH + 1)'(PAGE_NUM);

  state_t                 state_q, state_d;
  logic [ADDR_BITWIDTH:0] page_cnt_q;
  logic                   word_cnt_q;
  logic [QUAN_SIZE-1:0]   upper_q;
  logic                   s1_vld_q, s1_id_q, s1_sel_q;
  logic [REQ_NUM-1:0]     req, gnt;
  logic                   load_beat, load_last_wr, load_enter, arb_en;

  assign busy_o       = (state_q == LOAD);
  assign load_beat    = (state_q == LOAD) && load_valid_i;
  // page_cnt has already advanced past the final page while its write is on the port
  assign load_last_wr = (state_q == LOAD) && mem_we_o && (page_cnt_q == PAGE_END);
  assign load_enter   = (state_q != LOAD) && (state_d == LOAD);
  assign arb_en       = (state_q == READY) && !load_start_i;
  assign req          = {r1_req_i, r0_req_i};
  assign r0_gnt_o     = gnt[0];
  assign r1_gnt_o     = gnt[1];
  assign rd_word_o    = mem_word_i;

  rr_arbiter_2 u_arb (
    .sys_clk (sys_clk),
    .rstn    (rstn),
    .en      (arb_en),
    .req     (req),
    .gnt     (gnt)
  );

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, READY: if (load_start_i) state_d = LOAD;
      LOAD:        if (load_last_wr) state_d = READY;
      default:     state_d = IDLE;
    endcase
  end

  // Word packer: first beat of a pair fills the upper half, second launches the write.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      page_cnt_q  <= '0;
      word_cnt_q  <= 1'b0;
      upper_q     <= '0;
      mem_we_o    <= 1'b0;
      mem_wdata_o <= '0;
      load_done_o <= 1'b0;
    end else begin
      mem_we_o <= 1'b0;
      if (load_enter) begin
        page_cnt_q  <= '0;
        word_cnt_q  <= 1'b0;
        load_done_o <= 1'b0;
      end else if (load_beat) begin
        if (!word_cnt_q) begin
          upper_q    <= load_word_i;
          word_cnt_q <= 1'b1;
        end else begin
          mem_we_o    <= 1'b1;
          mem_wdata_o <= {upper_q, load_word_i};
          page_cnt_q  <= page_cnt_q + 1'b1;
          word_cnt_q  <= 1'b0;
        end
      end
      if (load_last_wr) begin
        load_done_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      mem_addr_o <= '0;
    end else if (load_beat && word_cnt_q) begin
      mem_addr_o <= page_cnt_q[ADDR_BITWIDTH-1:0];
    end else if (gnt[0]) begin
      mem_addr_o <= r0_addr_i[ADDR_BITWIDTH:1];
    end else if (gnt[1]) begin
      mem_addr_o <= r1_addr_i[ADDR_BITWIDTH:1];
    end
  end

  // Read return pipe keeps running across a reload so in-flight reads still complete.
  always_ff @(posedge sys_clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld_q      <= 1'b0;
      s1_id_q       <= 1'b0;
      s1_sel_q      <= 1'b0;
      mem_strobe_o  <= 1'b0;
      r0_rd_valid_o <= 1'b0;
      r1_rd_valid_o <= 1'b0;
    end else begin
      s1_vld_q      <= |gnt;
      s1_id_q       <= gnt[1];
      s1_sel_q      <= gnt[1] ? r1_addr_i[0] : r0_addr_i[0];
      mem_strobe_o  <= s1_sel_q;
      r0_rd_valid_o <= s1_vld_q && !s1_id_q;
      r1_rd_valid_o <= s1_vld_q && s1_id_q;
    end
  end

endmodule

// File: tb/tb_ib_lut_mem_ctrl.sv
// Bench for ib_lut_mem_ctrl: directed vector table plus randomized loads/reads
// checked against a per-cycle behavioural model and a simple registered memory.
module tb_ib_lut_mem_ctrl;
  import ib_lut_ctrl_pkg::*;

  logic                     sys_clk, rstn;
  logic                     load_start_i, load_valid_i;
  logic [QUAN_SIZE-1:0]     load_word_i;
  logic                     load_done_o, busy_o;
  logic                     r0_req_i, r1_req_i;
  logic [ADDR_BITWIDTH:0]   r0_addr_i, r1_addr_i;
  logic                     r0_gnt_o, r1_gnt_o, r0_rd_valid_o, r1_rd_valid_o;
  logic [QUAN_SIZE-1:0]     rd_word_o;
  logic [ADDR_BITWIDTH-1:0] mem_addr_o;
  logic                     mem_we_o;
  logic [PAGE_SIZE-1:0]     mem_wdata_o;
  logic                     mem_strobe_o;
  logic [QUAN_SIZE-1:0]     mem_word_i;

  int checks = 0;
  int failures = 0;

  ib_lut_mem_ctrl dut (
    .sys_clk(sys_clk), .rstn(rstn),
    .load_start_i(load_start_i), .load_valid_i(load_valid_i), .load_word_i(load_word_i),
    .load_done_o(load_done_o), .busy_o(busy_o),
    .r0_req_i(r0_req_i), .r1_req_i(r1_req_i), .r0_addr_i(r0_addr_i), .r1_addr_i(r1_addr_i),
    .r0_gnt_o(r0_gnt_o), .r1_gnt_o(r1_gnt_o),
    .r0_rd_valid_o(r0_rd_valid_o), .r1_rd_valid_o(r1_rd_valid_o), .rd_word_o(rd_word_o),
    .mem_addr_o(mem_addr_o), .mem_we_o(mem_we_o), .mem_wdata_o(mem_wdata_o),
    .mem_strobe_o(mem_strobe_o), .mem_word_i(mem_word_i)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // Distributed LUT memory: synchronous write, registered page read, word mux after the register.
  logic [PAGE_SIZE-1:0] mem_arr [PAGE_NUM];
  logic [PAGE_SIZE-1:0] rd_q;
  always @(posedge sys_clk) begin
    if (mem_we_o) mem_arr[mem_addr_o] <= mem_wdata_o;
    rd_q <= mem_arr[mem_addr_o];
  end
  assign mem_word_i = mem_strobe_o ? rd_q[QUAN_SIZE-1:0] : rd_q[PAGE_SIZE-1:QUAN_SIZE];

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct { int due; logic id; logic [QUAN_SIZE-1:0] word; } rd_t;
  rd_t pend [$];
  rd_t cur;
  int  cyc = 0;
  int  mode = 0;          // 0 idle, 1 loading, 2 serving reads
  int  beats = 0;
  int  we_count = 0;
  logic [QUAN_SIZE-1:0] upper_w;
  logic wr_due = 1'b0, write_now;
  int   wr_page;
  logic [PAGE_SIZE-1:0] wr_data;
  logic [PAGE_SIZE-1:0] model_tbl [PAGE_NUM];
  logic last_r1 = 1'b1;
  logic e_v0, e_v1, g0, g1;
  logic [QUAN_SIZE-1:0] e_w;
  logic [ADDR_BITWIDTH:0] gaddr;
  int nxt;

  always @(posedge sys_clk) begin
    #4;
    cyc++;
    if (mem_we_o === 1'b1) we_count++;
    if (!rstn) begin
      compare("rst_done", load_done_o, 0);
      compare("rst_busy", busy_o, 0);
      compare("rst_we", mem_we_o, 0);
      compare("rst_addr", mem_addr_o, 0);
      compare("rst_wdata", mem_wdata_o, 0);
      compare("rst_strobe", mem_strobe_o, 0);
      compare("rst_v0", r0_rd_valid_o, 0);
      compare("rst_v1", r1_rd_valid_o, 0);
      mode = 0; beats = 0; wr_due = 1'b0; last_r1 = 1'b1;
      pend.delete();
    end else begin
      e_v0 = 1'b0; e_v1 = 1'b0; e_w = '0;
      if (pend.size() > 0 && pend[0].due == cyc) begin
        cur = pend.pop_front();
        e_v0 = !cur.id; e_v1 = cur.id; e_w = cur.word;
      end
      compare("busy", busy_o, mode == 1);
      compare("load_done", load_done_o, mode == 2);
      compare("mem_we", mem_we_o, wr_due);
      if (wr_due) begin
        compare("wr_addr", mem_addr_o, wr_page);
        compare("wr_data", mem_wdata_o, wr_data);
      end
      compare("r0_valid", r0_rd_valid_o, e_v0);
      compare("r1_valid", r1_rd_valid_o, e_v1);
      if (e_v0 || e_v1) compare("rd_word", rd_word_o, e_w);

      g0 = 1'b0; g1 = 1'b0;
      if (mode == 2 && !load_start_i) begin
        if (r0_req_i && r1_req_i) begin g0 = last_r1; g1 = !last_r1; end
        else begin g0 = r0_req_i; g1 = r1_req_i; end
      end
      compare("r0_gnt", r0_gnt_o, g0);
      compare("r1_gnt", r1_gnt_o, g1);
      if (g0 || g1) begin
        gaddr = g1 ? r1_addr_i : r0_addr_i;
        cur.due = cyc + 2;
        cur.id = g1;
        cur.word = gaddr[0] ? model_tbl[gaddr[ADDR_BITWIDTH:1]][QUAN_SIZE-1:0]
                            : model_tbl[gaddr[ADDR_BITWIDTH:1]][PAGE_SIZE-1:QUAN_SIZE];
        pend.push_back(cur);
        last_r1 = g1;
      end

      nxt = mode;
      write_now = wr_due;
      wr_due = 1'b0;
      if (write_now) model_tbl[wr_page] = wr_data;
      if (mode == 1) begin
        if (write_now && wr_page == PAGE_NUM - 1) nxt = 2;
        else if (load_valid_i && beats < 2 * PAGE_NUM) begin
          if (beats % 2 == 0) upper_w = load_word_i;
          else begin
            wr_due = 1'b1; wr_page = beats / 2; wr_data = {upper_w, load_word_i};
          end
          beats++;
        end
      end else if (load_start_i) begin
        nxt = 1; beats = 0;
      end
      mode = nxt;
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic ls; logic q0; logic [ADDR_BITWIDTH:0] a0; logic q1; logic [ADDR_BITWIDTH:0] a1;
    logic g0; logic g1; logic v0; logic v1; logic [QUAN_SIZE-1:0] w; logic busy; logic done;
  } vec_t;
  vec_t vecs [19];
  logic [PAGE_SIZE-1:0] load_tbl [PAGE_NUM];
  logic [2:0] pb;
  logic g0_seen, g1_seen;

  task automatic nextCycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic checkOutput(input vec_t v, input int i);
    compare($sformatf("vec%0d_gnt0", i), r0_gnt_o, v.g0);
    compare($sformatf("vec%0d_gnt1", i), r1_gnt_o, v.g1);
    compare($sformatf("vec%0d_val0", i), r0_rd_valid_o, v.v0);
    compare($sformatf("vec%0d_val1", i), r1_rd_valid_o, v.v1);
    compare($sformatf("vec%0d_busy", i), busy_o, v.busy);
    compare($sformatf("vec%0d_done", i), load_done_o, v.done);
    if (v.v0 || v.v1) compare($sformatf("vec%0d_word", i), rd_word_o, v.w);
  endtask

  task automatic applyStimulus(input vec_t v, input int i);
    nextCycle();
    load_start_i = v.ls;
    r0_req_i = v.q0; r0_addr_i = v.a0;
    r1_req_i = v.q1; r1_addr_i = v.a1;
    #3;
    checkOutput(v, i);
  endtask

  task automatic startLoad();
    nextCycle();
    load_start_i = 1'b1;
  endtask

  task automatic feedLoad(input int n_beats, input bit gaps);
    int b = 0;
    int guard = 0;
    while (b < n_beats && guard < 1000) begin
      nextCycle();
      load_start_i = gaps && ($urandom_range(0, 7) == 0);
      if (gaps && $urandom_range(0, 3) == 0) begin
        load_valid_i = 1'b0;
      end else begin
        load_valid_i = 1'b1;
        load_word_i = (b % 2 == 0) ? load_tbl[b/2][PAGE_SIZE-1:QUAN_SIZE] : load_tbl[b/2][QUAN_SIZE-1:0];
        b++;
      end
      guard++;
    end
    nextCycle();
    load_start_i = 1'b0;
    load_valid_i = 1'b0;
  endtask

  task automatic waitDone();
    int n = 0;
    #3;
    while (load_done_o !== 1'b1 && n < 20) begin
      nextCycle();
      #3;
      n++;
    end
    compare("load_done_seen", load_done_o, 1);
  endtask

  task automatic doReset();
    nextCycle();
    rstn = 1'b0;
    load_start_i = 1'b0; load_valid_i = 1'b0; r0_req_i = 1'b0; r1_req_i = 1'b0;
    repeat (2) nextCycle();
    rstn = 1'b1;
    #3;
    compare("post_rst_done", load_done_o, 0);
    compare("post_rst_busy", busy_o, 0);
    compare("post_rst_addr", mem_addr_o, 0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout actual=running expected=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    //      ls q0 a0     q1 a1     g0 g1 v0 v1 w       busy done
    vecs[0]  = '{0, 1, 5'd10, 0, 5'd0,  1, 0, 0, 0, 3'b000, 0, 1};
    vecs[1]  = '{0, 0, 5'd0,  0, 5'd0,  0, 0, 0, 0, 3'b000, 0, 1};
    vecs[2]  = '{0, 0, 5'd0,  0, 5'd0,  0, 0, 1, 0, 3'b101, 0, 1};
    vecs[3]  = '{0, 1, 5'd11, 0, 5'd0,  1, 0, 0, 0, 3'b000, 0, 1};
    vecs[4]  = '{0, 0, 5'd0,  0, 5'd0,  0, 0, 0, 0, 3'b000, 0, 1};
    vecs[5]  = '{0, 0, 5'd0,  0, 5'd0,  0, 0, 1, 0, 3'b010, 0, 1};
    vecs[6]  = '{0, 0, 5'd0,  1, 5'd4,  0, 1, 0, 0, 3'b000, 0, 1};
    vecs[7]  = '{0, 0, 5'd0,  0, 5'd0,  0, 0, 0, 0, 3'b000, 0, 1};
    vecs[8]  = '{0, 1, 5'd6,  1, 5'd19, 1, 0, 0, 1, 3'b010, 0, 1};
    vecs[9]  = '{0, 1, 5'd9,  1, 5'd19, 0, 1, 0, 0, 3'b000, 0, 1};
    vecs[10] = '{0, 1, 5'd9,  1, 5'd20, 1, 0, 1, 0, 3'b011, 0, 1};
    vecs[11] = '{0, 1, 5'd12, 1, 5'd20, 0, 1, 0, 1, 3'b110, 0, 1};
    vecs[12] = '{0, 0, 5'd0,  0, 5'd0,  0, 0, 1, 0, 3'b011, 0, 1};
    vecs[13] = '{0, 0, 5'd0,  0, 5'd0,  0, 0, 0, 1, 3'b010, 0, 1};
    vecs[14] = '{0, 0, 5'd0,  0, 5'd0,  0, 0, 0, 0, 3'b000, 0, 1};
    vecs[15] = '{0, 1, 5'd14, 0, 5'd0,  1, 0, 0, 0, 3'b000, 0, 1};
    vecs[16] = '{0, 0, 5'd0,  1, 5'd16, 0, 1, 0, 0, 3'b000, 0, 1};
    vecs[17] = '{1, 1, 5'd2,  0, 5'd0,  0, 0, 1, 0, 3'b111, 0, 1};
    vecs[18] = '{0, 1, 5'd2,  0, 5'd0,  0, 0, 0, 1, 3'b000, 1, 0};

    for (int p = 0; p < PAGE_NUM; p++) begin
      pb = p[2:0];
      load_tbl[p] = {pb, ~pb};
    end

    rstn = 1'b0;
    load_start_i = 1'b0; load_valid_i = 1'b0; load_word_i = '0;
    r0_req_i = 1'b0; r1_req_i = 1'b0; r0_addr_i = '0; r1_addr_i = '0;
    repeat (3) nextCycle();
    rstn = 1'b1;

    // Full load with gaps and ignored restarts while r1 waits for the table.
    r1_req_i = 1'b1; r1_addr_i = {4'd5, 1'b1};
    startLoad();
    feedLoad(2 * PAGE_NUM, 1'b1);
    waitDone();
    compare("first_ready_gnt", r1_gnt_o, 1);
    compare("we_pulses", we_count, PAGE_NUM);
    compare("page5_content", mem_arr[5], 6'b101_010);
    nextCycle();
    r1_req_i = 1'b0;
    repeat (3) nextCycle();

    $display("[TB] directed vector table");
    for (int i = 0; i < 19; i++) applyStimulus(vecs[i], i);

    // Reset in the middle of a reload, after seven pages have been written.
    nextCycle();
    r0_req_i = 1'b0;
    feedLoad(14, 1'b0);
    nextCycle();
    doReset();

    for (int p = 0; p < PAGE_NUM; p++) load_tbl[p] = PAGE_SIZE'($urandom_range(0, 63));
    startLoad();
    feedLoad(2 * PAGE_NUM, 1'b1);
    waitDone();

    $display("[TB] random read traffic");
    g0_seen = 1'b1; g1_seen = 1'b1;
    for (int c = 0; c < 300; c++) begin
      nextCycle();
      if (!r0_req_i || g0_seen) begin
        r0_req_i = 1'($urandom_range(0, 1)); r0_addr_i = 5'($urandom_range(0, 31));
      end
      if (!r1_req_i || g1_seen) begin
        r1_req_i = 1'($urandom_range(0, 1)); r1_addr_i = 5'($urandom_range(0, 31));
      end
      #3;
      g0_seen = r0_gnt_o; g1_seen = r1_gnt_o;
    end
    nextCycle();
    r0_req_i = 1'b0; r1_req_i = 1'b0;
    repeat (4) nextCycle();
    #3;
    compare("pending_drained", pend.size(), 0);

    // A read in flight when reset hits must never return a valid.
    nextCycle();
    r0_req_i = 1'b1; r0_addr_i = {4'd3, 1'b0};
    nextCycle();
    r0_req_i = 1'b0;
    doReset();
    repeat (3) nextCycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
